sys_bus_ctrl: RTL and testbench

Parametrised single-master system bus controller between the rv32i core's data port and N memory-mapped slaves (data RAM, LED bar, TTY, future peripherals). It replaces fixed single-cycle address decoding with a registered request/acknowledge handshake. Slaves may insert wait states. The block adds decode-error and timeout-error reporting, and a saturating error counter for debug.

---
 rtl/sys_bus_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sys_bus_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl: single-master request/ack bus controller for N slaves.
// Decodes a slot field, handles wait states, decode errors and timeouts.
//
// Ports:
//   clk_i, rst_in              clock, async active-low reset
//   m_req_i/m_we_i/m_addr_i    master request, direction, byte address
//   m_wdata_i/m_be_i           master write data and byte enables
//   m_rdata_o                  registered read data
//   m_ack_o/m_err_o            completion pulse, error flag with ack
//   s_req_o                    one-hot slave request
//   s_we_o/s_addr_o            latched direction, slot-local address
//   s_wdata_o/s_be_o           latched write data and byte enables
//   s_rdata_i/s_ack_i          per-slot read data (32b each) and ack
//   busy_o                     transaction in progress
//   err_cnt_o                  saturating error-completion count
module sys_bus_ctrl #(
  parameter int N_SLV   = 4,
  parameter int SEL_MSB = 31,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_in,
  input  logic                  m_req_i,
  input  logic                  m_we_i,
  input  logic [31:0]           m_addr_i,
  input  logic [31:0]           m_wdata_i,
  input  logic [3:0]            m_be_i,
  output logic [31:0]           m_rdata_o,
  output logic                  m_ack_o,
  output logic                  m_err_o,
  output logic [N_SLV-1:0]      s_req_o,
  output logic                  s_we_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_wdata_o,
  output logic [3:0]            s_be_o,
  input  logic [32*N_SLV-1:0]   s_rdata_i,
  input  logic [N_SLV-1:0]      s_ack_i,
  output logic                  busy_o,
  output logic [15:0]           err_cnt_o
);

  localparam int SW = SEL_MSB - SEL_LSB + 1;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam logic [31:0] ADDR_MASK = (32'd1 << SEL_LSB) - 32'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [SW-1:0]    w_slot;
  logic [SW-1:0]    r_slot;
  logic             w_dec_ok;
  logic [N_SLV-1:0] w_hot;
  logic [31:0]      w_rdata;
  logic             w_ack;
  logic             w_to;
  logic             w_ack_o;
  logic             w_err_o;
  logic             w_busy;

  logic [N_SLV-1:0] r_sreq;
  logic [CW-1:0]    r_wcnt;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic [31:0]      r_rdata;
  logic [15:0]      r_errcnt;

  // Slot decode for the incoming request and read-back mux for the
  // latched slot; equality loops keep out-of-range slots harmless.
  always_comb begin
    w_slot   = m_addr_i[SEL_MSB:SEL_LSB];
    w_dec_ok = 1'b0;
    w_hot    = '0;
    w_rdata  = '0;
    w_ack    = 1'b0;
    for (int k = 0; k < N_SLV; k++) begin
      if (w_slot == SW'(k)) begin
        w_dec_ok = 1'b1;
        w_hot[k] = 1'b1;
      end
      if (r_slot == SW'(k)) begin
        w_rdata = s_rdata_i[32*k +: 32];
        w_ack   = s_ack_i[k];
      end
    end
  end

  assign w_to = (TIMEOUT != 0) && (r_wcnt == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt   = r_state;
    w_ack_o = 1'b0;
    w_err_o = 1'b0;
    w_busy  = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (m_req_i) begin
          w_nxt = w_dec_ok ? S_ACCESS : S_ERR;
        end
      end
      S_ACCESS: begin
        // Ack beats a timeout that lands on the same edge.
        if (w_ack) begin
          w_nxt = S_RESP;
        end else if (w_to) begin
          w_nxt = S_ERR;
        end
      end
      S_RESP: begin
        w_ack_o = 1'b1;
        w_nxt   = S_IDLE;
      end
      S_ERR: begin
        w_ack_o = 1'b1;
        w_err_o = 1'b1;
        w_nxt   = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_slot   <= '0;
      r_sreq   <= '0;
      r_wcnt   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_rdata  <= '0;
      r_errcnt <= '0;
    end else begin
      if (r_state == S_IDLE && m_req_i) begin
        r_slot  <= w_slot;
        r_we    <= m_we_i;
        r_addr  <= m_addr_i & ADDR_MASK;
        r_wdata <= m_wdata_i;
        r_be    <= m_be_i;
        r_wcnt  <= '0;
        r_sreq  <= w_hot;
      end
      if (r_state == S_ACCESS) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (w_nxt != S_ACCESS) begin
          r_sreq <= '0;
        end
        if (w_ack && !r_we) begin
          r_rdata <= w_rdata;
        end
      end
      // Count on entry so the counter already reflects the error
      // while its ack is on the bus.
      if (w_nxt == S_ERR && r_state != S_ERR) begin
        r_rdata <= '0;
        if (r_errcnt != 16'hFFFF) begin
          r_errcnt <= r_errcnt + 16'd1;
        end
      end
    end
  end

  assign m_rdata_o = r_rdata;
  assign m_ack_o   = w_ack_o;
  assign m_err_o   = w_err_o;
  assign s_req_o   = r_sreq;
  assign s_we_o    = r_we;
  assign s_addr_o  = r_addr;
  assign s_wdata_o = r_wdata;
  assign s_be_o    = r_be;
  assign busy_o    = w_busy;
  assign err_cnt_o = r_errcnt;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// tb_sys_bus_ctrl: scoreboard bench for sys_bus_ctrl.
// Slave models with programmable waits; ack-side monitor pops expectations.
module tb_sys_bus_ctrl;

  localparam int N  = 4;
  localparam int TO = 8;

  logic            clk_i = 1'b0;
  logic            rst_in;
  logic            m_req_i;
  logic            m_we_i;
  logic [31:0]     m_addr_i;
  logic [31:0]     m_wdata_i;
  logic [3:0]      m_be_i;
  logic [31:0]     m_rdata_o;
  logic            m_ack_o;
  logic            m_err_o;
  logic [N-1:0]    s_req_o;
  logic            s_we_o;
  logic [31:0]     s_addr_o;
  logic [31:0]     s_wdata_o;
  logic [3:0]      s_be_o;
  logic [32*N-1:0] s_rdata_i;
  logic [N-1:0]    s_ack_i;
  logic            busy_o;
  logic [15:0]     err_cnt_o;

  always #5 clk_i = ~clk_i;

  sys_bus_ctrl #(
    .N_SLV  (N),
    .SEL_MSB(31),
    .SEL_LSB(28),
    .TIMEOUT(TO)
  ) u_dut (
    .clk_i    (clk_i),
    .rst_in   (rst_in),
    .m_req_i  (m_req_i),
    .m_we_i   (m_we_i),
    .m_addr_i (m_addr_i),
    .m_wdata_i(m_wdata_i),
    .m_be_i   (m_be_i),
    .m_rdata_o(m_rdata_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_req_o  (s_req_o),
    .s_we_o   (s_we_o),
    .s_addr_o (s_addr_o),
    .s_wdata_o(s_wdata_o),
    .s_be_o   (s_be_o),
    .s_rdata_i(s_rdata_i),
    .s_ack_i  (s_ack_i),
    .busy_o   (busy_o),
    .err_cnt_o(err_cnt_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  sreq;
    int          ncyc;
    int          req_cyc;
  } txn_t;

  txn_t q[$];
  txn_t mon_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_errcnt = 0;
  logic [31:0] exp_rd = '0;

  int          wait_cfg[N];
  logic [31:0] rd_cfg[N];
  int          scnt[N] = '{default: 0};
  logic [N-1:0] force_ack = '0;

  logic [3:0] seen_or = '0;
  int         seen_n = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      scnt[k] <= s_req_o[k] ? scnt[k] + 1 : 0;
    end
  end

  always_comb begin
    s_ack_i   = '0;
    s_rdata_i = '0;
    for (int k = 0; k < N; k++) begin
      s_ack_i[k] = (s_req_o[k] && scnt[k] == wait_cfg[k]) || force_ack[k];
      s_rdata_i[32*k +: 32] = rd_cfg[k];
    end
  end

  always @(negedge clk_i) begin
    if (!rst_in) begin
      seen_or = '0;
      seen_n  = 0;
    end else begin
      if (s_req_o != '0) begin
        seen_or = seen_or | s_req_o;
        seen_n++;
      end
      if (m_ack_o) begin
        if (q.size() == 0) begin
          chk("spurious_ack", 32'(m_ack_o), 32'd0);
        end else begin
          mon_t = q.pop_front();
          chk("err", 32'(m_err_o), 32'(mon_t.err));
          chk("rdata", m_rdata_o, mon_t.rdata);
          chk("sreq_set", 32'(seen_or), 32'(mon_t.sreq));
          chk("sreq_cycles", seen_n, mon_t.ncyc);
          chk("latency", cyc - mon_t.req_cyc, mon_t.ncyc + 1);
          chk("saddr", s_addr_o, mon_t.addr & 32'h0FFF_FFFF);
          chk("swe", 32'(s_we_o), 32'(mon_t.we));
          chk("swdata", s_wdata_o, mon_t.wdata);
          chk("sbe", 32'(s_be_o), 32'(mon_t.be));
        end
        seen_or = '0;
        seen_n  = 0;
      end
    end
  end

  task automatic run(input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [3:0] sreq, input int ncyc,
                     input logic err);
    txn_t t;
    int   slot;
    bit   got;
    slot    = int'(addr[31:28]);
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.be    = be;
    t.err   = err;
    t.sreq  = sreq;
    t.ncyc  = ncyc;
    if (err) t.rdata = '0;
    else if (we) t.rdata = exp_rd;
    else t.rdata = rd_cfg[slot];
    @(negedge clk_i);
    t.req_cyc = cyc;
    q.push_back(t);
    m_we_i    = we;
    m_addr_i  = addr;
    m_wdata_i = wdata;
    m_be_i    = be;
    m_req_i   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      if (m_ack_o) got = 1'b1;
    end
    m_req_i = 1'b0;
    if (!got) begin
      chk("ack_wait", 32'(got), 32'd1);
      q.delete();
    end
    exp_rd = t.rdata;
    if (err) exp_errcnt++;
    @(negedge clk_i);
    chk("errcnt", 32'(err_cnt_o), exp_errcnt);
    chk("idle_after", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rd_cfg[0] = 32'hCAFE_0001;
    rd_cfg[1] = 32'h1111_1111;
    rd_cfg[2] = 32'h2222_2222;
    rd_cfg[3] = 32'h3333_3333;
    for (int k = 0; k < N; k++) wait_cfg[k] = 0;
    rst_in    = 1'b0;
    m_req_i   = 1'b0;
    m_we_i    = 1'b0;
    m_addr_i  = '0;
    m_wdata_i = '0;
    m_be_i    = '0;

    repeat (3) begin
      @(negedge clk_i);
      m_req_i   = 1'b1;
      m_we_i    = 1'($urandom);
      m_addr_i  = $urandom;
      m_wdata_i = $urandom;
      m_be_i    = 4'($urandom);
      force_ack = N'($urandom);
    end
    @(negedge clk_i);
    chk("rst_sreq", 32'(s_req_o), 32'd0);
    chk("rst_ack", 32'(m_ack_o), 32'd0);
    chk("rst_err", 32'(m_err_o), 32'd0);
    chk("rst_rdata", m_rdata_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_errcnt", 32'(err_cnt_o), 32'd0);
    chk("rst_saddr", s_addr_o, 32'd0);
    chk("rst_swdata", s_wdata_o, 32'd0);
    chk("rst_sbe", 32'(s_be_o), 32'd0);
    chk("rst_swe", 32'(s_we_o), 32'd0);
    m_req_i   = 1'b0;
    force_ack = '0;
    @(negedge clk_i);
    rst_in = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("idle_busy", 32'(busy_o), 32'd0);
    end

    run(1'b0, 32'h0000_0010, 32'h0, 4'hF, 4'b0001, 1, 1'b0);
    wait_cfg[2] = 2;
    run(1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 4'b0100, 3, 1'b0);
    run(1'b0, 32'h5000_0000, 32'h0, 4'hF, 4'b0000, 0, 1'b1);
    wait_cfg[1] = 1000;
    run(1'b0, 32'h1000_0020, 32'h0, 4'hF, 4'b0010, TO, 1'b1);
    wait_cfg[1] = TO - 1;
    run(1'b0, 32'h1000_0024, 32'h0, 4'hF, 4'b0010, TO, 1'b0);
    run(1'b0, 32'h3000_00FC, 32'h0, 4'hF, 4'b1000, 1, 1'b0);
    run(1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 4'b1000, 4'b0001, 1, 1'b0);
    run(1'b0, 32'hF000_0000, 32'h0, 4'hF, 4'b0000, 0, 1'b1);

    // Wrong-slot ack, early master drop, then reset mid-access.
    wait_cfg[3] = 1000;
    @(negedge clk_i);
    m_we_i   = 1'b0;
    m_addr_i = 32'h3000_0008;
    m_req_i  = 1'b1;
    @(negedge clk_i);
    chk("mid_sreq", 32'(s_req_o), 32'b1000);
    m_req_i   = 1'b0;
    force_ack = 4'b0001;
    @(negedge clk_i);
    force_ack = '0;
    chk("wrong_ack_busy", 32'(busy_o), 32'd1);
    chk("wrong_ack_noack", 32'(m_ack_o), 32'd0);
    chk("wrong_ack_sreq", 32'(s_req_o), 32'b1000);
    @(posedge clk_i);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_sreq", 32'(s_req_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_ack", 32'(m_ack_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_in = 1'b1;
    exp_errcnt = 0;
    exp_rd = '0;
    chk("arst_errcnt", 32'(err_cnt_o), 32'd0);
    chk("arst_rdata", m_rdata_o, 32'd0);

    wait_cfg[2] = 1;
    run(1'b0, 32'h2000_0100, 32'h0, 4'hF, 4'b0100, 2, 1'b0);

    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
